// File: rtl/frame_packetizer.sv
// TX frame packetizer: preamble/mode/length/padding header, backpressured payload, optional CRC-16 trailer.
// state   | meaning
// S_IDLE  | bypass pass-through, or latch packet parameters on first valid beat (MIX)
// S_HDR   | emit header symbols, one bit per beat
// S_PLD   | forward payload beats and fold them into the CRC
// S_CRC   | emit 16 CRC symbols, MSB first
// S_FLUSH | discard overlong input until tlast or a gap in tvalid
// S_DONE  | wait for the last beat to leave the output register
module frame_packetizer #(
  parameter int BYTES         = 1,
  parameter int PREAMBLE_BITS = 256,
  parameter int FLIP_BITS     = 32,
  parameter int LEN_WIDTH     = 16,
  parameter int PAD_BITS      = 40,
  parameter int CRC_EN        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_enable,
  input  logic [3:0]           MODE_CTRL,
  input  logic [LEN_WIDTH-1:0] payload_length,
  input  logic [8*BYTES-1:0]   I_tdata,
  input  logic                 I_tvalid,
  output logic                 I_tready,
  input  logic                 I_tlast,
  input  logic                 I_tuser,
  output logic [8*BYTES-1:0]   O_tdata,
  output logic                 O_tvalid,
  input  logic                 O_tready,
  output logic                 O_tlast,
  output logic                 O_tuser,
  output logic                 hdr_vld,
  output logic                 crc_vld,
  output logic                 err_short,
  output logic                 err_long,
  output logic                 pkt_sent
);

  localparam int BITS    = 8 * BYTES;
  localparam int HDR_LEN = PREAMBLE_BITS + 8 + LEN_WIDTH + PAD_BITS;
  localparam int HCW     = ($clog2(HDR_LEN) > 10) ? $clog2(HDR_LEN) : 10;

  localparam logic [HCW-1:0]       HDR_LAST  = HCW'(HDR_LEN - 1);
  localparam logic [HCW-1:0]       HCNT_ONE  = HCW'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0] LEN_MSB   = {1'b1, {(LEN_WIDTH-1){1'b0}}};
  localparam logic [3:0]           MODE_MIX  = 4'b0100;
  localparam logic                 HAS_CRC   = (CRC_EN != 0);
  localparam logic                 PAD_PHASE = 1'((PREAMBLE_BITS + 8 + LEN_WIDTH) % 2);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_PLD, S_CRC, S_FLUSH, S_DONE} state_t;

  state_t               state;
  logic [HCW-1:0]       hcnt;
  logic [LEN_WIDTH-1:0] pcnt;
  logic [3:0]           ccnt;
  logic [15:0]          crc_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic                 is_bpsk;
  logic                 flush_pend;

  logic                 load;
  logic                 mix_in;
  logic                 pld_last;
  logic                 hdr_bit;
  int                   hdr_idx;
  logic [7:0]           mode_byte;
  logic [7:0]           mode_sel;
  logic [LEN_WIDTH-1:0] len_sel;
  logic [15:0]          crc_pld;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic d);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ d) ? 16'h1021 : 16'h0000);
  endfunction

  assign load      = !O_tvalid || O_tready;
  assign mix_in    = (MODE_CTRL == MODE_MIX);
  assign pld_last  = (pcnt == LEN_ONE);
  assign mode_byte = is_bpsk ? 8'hAA : 8'h55;
  assign crc_pld   = is_bpsk ? crc_step(crc_q, I_tdata[0])
                             : crc_step(crc_step(crc_q, I_tdata[1]), I_tdata[0]);

  always_comb begin
    I_tready = 1'b0;
    if (clk_enable) begin
      case (state)
        S_IDLE:  I_tready = !mix_in && load;
        S_PLD:   I_tready = load;
        S_FLUSH: I_tready = 1'b1;
        default: I_tready = 1'b0;
      endcase
    end
  end

  // Header symbol generator indexed by the header counter.
  always_comb begin
    hdr_idx  = int'(hcnt);
    mode_sel = '0;
    len_sel  = '0;
    hdr_bit  = 1'b0;
    if (hdr_idx < PREAMBLE_BITS) begin
      hdr_bit = hcnt[0] ^ (hdr_idx >= PREAMBLE_BITS - FLIP_BITS);
    end else if (hdr_idx < PREAMBLE_BITS + 8) begin
      mode_sel = 8'h80 >> (hdr_idx - PREAMBLE_BITS);
      hdr_bit  = |(mode_byte & mode_sel);
    end else if (hdr_idx < PREAMBLE_BITS + 8 + LEN_WIDTH) begin
      len_sel = LEN_MSB >> (hdr_idx - PREAMBLE_BITS - 8);
      hdr_bit = |(len_q & len_sel);
    end else begin
      hdr_bit = hcnt[0] ^ PAD_PHASE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      hcnt       <= '0;
      pcnt       <= '0;
      ccnt       <= '0;
      crc_q      <= 16'hFFFF;
      len_q      <= '0;
      is_bpsk    <= 1'b0;
      flush_pend <= 1'b0;
      O_tdata    <= '0;
      O_tvalid   <= 1'b0;
      O_tlast    <= 1'b0;
      O_tuser    <= 1'b1;
      hdr_vld    <= 1'b0;
      crc_vld    <= 1'b0;
      err_short  <= 1'b0;
      err_long   <= 1'b0;
      pkt_sent   <= 1'b0;
    end else if (clk_enable) begin
      err_short <= 1'b0;
      err_long  <= 1'b0;
      pkt_sent  <= 1'b0;
      // Output register drains by default; a branch below may reload it.
      if (load) begin
        O_tvalid <= 1'b0;
        hdr_vld  <= 1'b0;
        crc_vld  <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (mix_in) begin
            if (I_tvalid) begin
              is_bpsk    <= I_tuser;
              len_q      <= payload_length;
              pcnt       <= I_tuser ? payload_length : (payload_length >> 1);
              crc_q      <= 16'hFFFF;
              hcnt       <= '0;
              ccnt       <= '0;
              flush_pend <= 1'b0;
              state      <= S_HDR;
            end
          end else if (I_tvalid && load) begin
            O_tdata  <= I_tdata;
            O_tlast  <= I_tlast;
            O_tuser  <= I_tuser;
            O_tvalid <= 1'b1;
          end
        end

        S_HDR: begin
          if (load) begin
            O_tdata  <= {BITS{hdr_bit}};
            O_tvalid <= 1'b1;
            O_tuser  <= 1'b1;
            hdr_vld  <= 1'b1;
            O_tlast  <= (hcnt == HDR_LAST) && (pcnt == '0) && !HAS_CRC;
            hcnt     <= hcnt + HCNT_ONE;
            if (hcnt == HDR_LAST) begin
              if (pcnt != '0)   state <= S_PLD;
              else if (HAS_CRC) state <= S_CRC;
              else              state <= S_DONE;
            end
          end
        end

        S_PLD: begin
          if (I_tvalid && load) begin
            O_tdata  <= I_tdata;
            O_tvalid <= 1'b1;
            O_tuser  <= 1'b0;
            O_tlast  <= !HAS_CRC && (pld_last || I_tlast);
            crc_q    <= crc_pld;
            pcnt     <= pcnt - LEN_ONE;
            if (pld_last || I_tlast) begin
              err_short  <= I_tlast && !pld_last;
              flush_pend <= pld_last && !I_tlast;
              if (HAS_CRC)                    state <= S_CRC;
              else if (pld_last && !I_tlast)  state <= S_FLUSH;
              else                            state <= S_DONE;
            end
          end
        end

        S_CRC: begin
          if (load) begin
            O_tdata  <= {BITS{crc_q[15]}};
            crc_q    <= {crc_q[14:0], 1'b0};
            O_tvalid <= 1'b1;
            O_tuser  <= 1'b1;
            crc_vld  <= 1'b1;
            O_tlast  <= (ccnt == 4'd15);
            ccnt     <= ccnt + 4'd1;
            if (ccnt == 4'd15) state <= flush_pend ? S_FLUSH : S_DONE;
          end
        end

        S_FLUSH: begin
          if (I_tvalid) begin
            err_long <= 1'b1;
            if (I_tlast) state <= S_DONE;
          end else begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          if (!O_tvalid) begin
            pkt_sent <= 1'b1;
            state    <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
